// File: rtl/key_sched_256_seq.sv
// key_sched_256_seq
//   Sequential AES-256 round-key generator. It holds the current eight-word
//   window of the expanded key and emits it as two 128-bit round keys. After
//   each pair it spends one EXPAND cycle stepping the window forward by eight
//   words through a single combinational expansion step, which is the only
//   S-box logic in the block.
//
// Handshake: rk_valid/rk_ready. A round key transfers on a rising clk edge
//   where rk_valid && rk_ready. Once rk_valid is high, rk_data and rk_index
//   hold until that transfer. rk_valid only drops early on abort or reset.
//
// Ports
//   clk       rising-edge clock
//   rst_n     asynchronous active-low reset
//   start     begin a schedule (sampled in IDLE only, suppressed by abort)
//   abort     synchronous cancel of a schedule in progress
//   key_in    256-bit key, w0 in [255:224] down to w7 in [31:0]
//   rk_valid  round key presented
//   rk_ready  consumer accepts
//   rk_data   round key, w(4i) in [127:96] .. w(4i+3) in [31:0]
//   rk_index  round number of rk_data (0..14)
//   busy      high whenever the FSM is not in IDLE
//   done      one-cycle pulse after round key 14 transfers
module key_sched_256_seq (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic         abort,
  input  logic [255:0] key_in,
  output logic         rk_valid,
  input  logic         rk_ready,
  output logic [127:0] rk_data,
  output logic [3:0]   rk_index,
  output logic         busy,
  output logic         done
);

  typedef enum logic [1:0] {IDLE, EMIT_A, EMIT_B, EXPAND} state_t;

  state_t       state, state_nxt;
  logic [255:0] key_reg, key_nxt;
  logic [7:0]   rcon_reg, rcon_nxt;
  logic [3:0]   idx, idx_nxt;
  logic         done_nxt;

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] acc;
    logic [7:0] aa;
    acc = 8'h00;
    aa  = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) acc = acc ^ aa;
      aa = xtime(aa);
    end
    return acc;
  endfunction

  // S-box computed arithmetically: multiplicative inverse as x^254
  // (zero maps to zero), followed by the FIPS-197 affine transform.
  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] sq;
    logic [7:0] inv;
    sq  = x;
    inv = 8'h01;
    for (int i = 1; i < 8; i++) begin
      sq  = gf_mul(sq, sq);
      inv = gf_mul(inv, sq);
    end
    return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
           {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
  endfunction

  // One eight-word expansion step. The first half uses RotWord+SubWord+Rcon
  // on w7; the second half uses SubWord only on the freshly produced w3.
  logic [31:0]  t1, t2;
  logic [31:0]  n0, n1, n2, n3, n4, n5, n6, n7;
  logic [255:0] expanded;

  always_comb begin
    t1 = sub_word({key_reg[23:0], key_reg[31:24]}) ^ {rcon_reg, 24'h000000};
    n0 = key_reg[255:224] ^ t1;
    n1 = key_reg[223:192] ^ n0;
    n2 = key_reg[191:160] ^ n1;
    n3 = key_reg[159:128] ^ n2;
    t2 = sub_word(n3);
    n4 = key_reg[127:96]  ^ t2;
    n5 = key_reg[95:64]   ^ n4;
    n6 = key_reg[63:32]   ^ n5;
    n7 = key_reg[31:0]    ^ n6;
    expanded = {n0, n1, n2, n3, n4, n5, n6, n7};
  end

  always_comb begin
    state_nxt = state;
    key_nxt   = key_reg;
    rcon_nxt  = rcon_reg;
    idx_nxt   = idx;
    done_nxt  = 1'b0;
    rk_valid  = 1'b0;
    rk_data   = '0;
    rk_index  = '0;
    case (state)
      IDLE: begin
        if (start && !abort) begin
          key_nxt   = key_in;
          rcon_nxt  = 8'h01;
          idx_nxt   = 4'd0;
          state_nxt = EMIT_A;
        end
      end
      EMIT_A: begin
        rk_valid = 1'b1;
        rk_data  = key_reg[255:128];
        rk_index = idx;
        if (abort) begin
          state_nxt = IDLE;
        end else if (rk_ready) begin
          if (idx == 4'd14) begin
            state_nxt = IDLE;
            done_nxt  = 1'b1;
          end else begin
            idx_nxt   = idx + 4'd1;
            state_nxt = EMIT_B;
          end
        end
      end
      EMIT_B: begin
        rk_valid = 1'b1;
        rk_data  = key_reg[127:0];
        rk_index = idx;
        if (abort) begin
          state_nxt = IDLE;
        end else if (rk_ready) begin
          idx_nxt   = idx + 4'd1;
          state_nxt = EXPAND;
        end
      end
      EXPAND: begin
        if (abort) begin
          state_nxt = IDLE;
        end else begin
          key_nxt   = expanded;
          rcon_nxt  = xtime(rcon_reg);
          state_nxt = EMIT_A;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      key_reg  <= '0;
      rcon_reg <= 8'h01;
      idx      <= 4'd0;
      done     <= 1'b0;
    end else begin
      state    <= state_nxt;
      key_reg  <= key_nxt;
      rcon_reg <= rcon_nxt;
      idx      <= idx_nxt;
      done     <= done_nxt;
    end
  end

  assign busy = (state != IDLE);

endmodule

// File: tb/tb_key_sched_256_seq.sv
// tb_key_sched_256_seq
//   Bench for key_sched_256_seq. Expected round keys come from a textbook
//   FIPS-197 word-array key expansion using an S-box table built by the
//   generator walk (p *= 3, q /= 3), kept independent of the DUT arithmetic.
module tb_key_sched_256_seq;

  localparam logic [255:0] KEY_C3 =
    256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic         abort = 1'b0;
  logic [255:0] key_in = '0;
  logic         rk_valid;
  logic         rk_ready = 1'b1;
  logic [127:0] rk_data;
  logic [3:0]   rk_index;
  logic         busy;
  logic         done;

  int checks = 0;
  int errors = 0;
  int xfer_cnt = 0;
  bit rand_ready = 1'b0;

  logic [131:0] exp_q[$];
  logic [127:0] got_rk[16];
  logic [7:0]   sbox_tab[256];

  key_sched_256_seq dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .abort    (abort),
    .key_in   (key_in),
    .rk_valid (rk_valid),
    .rk_ready (rk_ready),
    .rk_data  (rk_data),
    .rk_index (rk_index),
    .busy     (busy),
    .done     (done)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- checking ----------------
  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic [7:0] rotl8(input logic [7:0] v, input int k);
    return (v << k) | (v >> (8 - k));
  endfunction

  task automatic init_sbox();
    logic [7:0] p, q, x;
    p = 8'h01;
    q = 8'h01;
    for (int n = 0; n < 255; n++) begin
      p = p ^ (p << 1) ^ (p[7] ? 8'h1b : 8'h00);
      q = q ^ (q << 1);
      q = q ^ (q << 2);
      q = q ^ (q << 4);
      if (q[7]) q = q ^ 8'h09;
      x = q ^ rotl8(q, 1) ^ rotl8(q, 2) ^ rotl8(q, 3) ^ rotl8(q, 4);
      sbox_tab[p] = x ^ 8'h63;
    end
    sbox_tab[0] = 8'h63;
  endtask

  function automatic logic [31:0] sub_w(input logic [31:0] w);
    return {sbox_tab[w[31:24]], sbox_tab[w[23:16]], sbox_tab[w[15:8]], sbox_tab[w[7:0]]};
  endfunction

  // Standard 60-word expansion; pushes the 15 expected {index, key} pairs.
  task automatic build_model(input logic [255:0] key);
    logic [31:0] w[60];
    logic [31:0] temp;
    logic [7:0]  rcon_tab[7];
    rcon_tab = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40};
    for (int i = 0; i < 8; i++) w[i] = key[255 - 32*i -: 32];
    for (int i = 8; i < 60; i++) begin
      temp = w[i-1];
      if (i % 8 == 0)
        temp = sub_w({temp[23:0], temp[31:24]}) ^ {rcon_tab[i/8 - 1], 24'h0};
      else if (i % 8 == 4)
        temp = sub_w(temp);
      w[i] = w[i-8] ^ temp;
    end
    exp_q.delete();
    for (int r = 0; r < 15; r++)
      exp_q.push_back({4'(r), w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]});
  endtask

  // ---------------- consumer ready driver ----------------
  initial begin
    forever begin
      @(posedge clk);
      #1 rk_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  // ---------------- scoreboard ----------------
  // Every presented key must match the head of the expected queue, which also
  // catches any change of data/index while the consumer stalls.
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n && rk_valid) begin
        if (exp_q.size() == 0) begin
          chk("spurious_valid", {127'b0, rk_valid}, 128'd0);
        end else begin
          chk("rk_index", {124'b0, rk_index}, {124'b0, exp_q[0][131:128]});
          chk("rk_data", rk_data, exp_q[0][127:0]);
          if (rk_ready) begin
            got_rk[rk_index] = rk_data;
            void'(exp_q.pop_front());
            xfer_cnt++;
          end
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic do_start(input logic [255:0] key);
    build_model(key);
    xfer_cnt = 0;
    for (int i = 0; i < 16; i++) got_rk[i] = '0;
    @(posedge clk);
    #1 start = 1'b1;
    key_in = key;
    @(posedge clk);
    #1 start = 1'b0;
    @(negedge clk);
    chk("first_valid", {127'b0, rk_valid}, 128'd1);
  endtask

  // With an always-ready consumer, the done edge lands 21 clock edges after
  // the edge that transfers round key 0 (14 transfers + 7 bubbles).
  task automatic wait_done(input bit check_cycles);
    int cyc;
    bit seen;
    cyc  = 0;
    seen = 1'b0;
    while (!seen && cyc < 400) begin
      @(negedge clk);
      if (done) seen = 1'b1;
      else cyc++;
    end
    chk("done_seen", {127'b0, done}, 128'd1);
    if (seen) begin
      chk("done_busy", {127'b0, busy}, 128'd0);
      chk("done_xfers", 128'(xfer_cnt), 128'd15);
      chk("done_queue_empty", 128'(exp_q.size()), 128'd0);
      if (check_cycles) chk("start_to_done", 128'(cyc), 128'd21);
      @(negedge clk);
      chk("done_width", {127'b0, done}, 128'd0);
    end
  endtask

  task automatic wait_index(input logic [3:0] target);
    int cyc;
    cyc = 0;
    @(negedge clk);
    while (!(rk_valid && rk_index == target) && cyc < 400) begin
      @(negedge clk);
      cyc++;
    end
    chk("reach_index", {124'b0, rk_index}, {124'b0, target});
  endtask

  task automatic check_idle_outputs(input string tag);
    chk({tag, "_valid"}, {127'b0, rk_valid}, 128'd0);
    chk({tag, "_busy"}, {127'b0, busy}, 128'd0);
    chk({tag, "_done"}, {127'b0, done}, 128'd0);
    chk({tag, "_data"}, rk_data, 128'd0);
    chk({tag, "_index"}, {124'b0, rk_index}, 128'd0);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    logic [255:0] rkey;
    int cyc;
    init_sbox();

    #3;
    check_idle_outputs("reset");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // FIPS-197 C.3 key, consumer always ready.
    rand_ready = 1'b0;
    do_start(KEY_C3);
    wait_done(1'b1);
    chk("c3_idx0", got_rk[0], 128'h000102030405060708090a0b0c0d0e0f);
    chk("c3_idx1", got_rk[1], 128'h101112131415161718191a1b1c1d1e1f);
    chk("c3_idx2", got_rk[2], 128'ha573c29fa176c498a97fce93a572c09c);
    chk("c3_idx14", got_rk[14], 128'h24fc79ccbf0979e9371ac23c6d68de36);

    // Same key, random backpressure.
    rand_ready = 1'b1;
    do_start(KEY_C3);
    wait_done(1'b0);
    chk("c3_stall_idx14", got_rk[14], 128'h24fc79ccbf0979e9371ac23c6d68de36);

    // start pulsed while busy at index 5 must be ignored.
    do_start(KEY_C3);
    wait_index(4'd5);
    start = 1'b1;
    key_in = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    @(posedge clk);
    #1 start = 1'b0;
    wait_done(1'b0);
    chk("busy_start_idx14", got_rk[14], 128'h24fc79ccbf0979e9371ac23c6d68de36);

    // abort in EMIT_B at index 7; the concurrent transfer still counts.
    rand_ready = 1'b0;
    do_start(KEY_C3);
    wait_index(4'd7);
    abort = 1'b1;
    @(posedge clk);
    #1 abort = 1'b0;
    @(negedge clk);
    chk("abort_valid", {127'b0, rk_valid}, 128'd0);
    chk("abort_busy", {127'b0, busy}, 128'd0);
    chk("abort_done", {127'b0, done}, 128'd0);
    chk("abort_xfers", 128'(xfer_cnt), 128'd8);
    chk("abort_left", 128'(exp_q.size()), 128'd7);
    do_start('0);
    wait_done(1'b1);
    chk("zero_idx2", got_rk[2], 128'h62636363626363636263636362636363);

    // Asynchronous reset during EXPAND, then a full C.3 run.
    do_start(KEY_C3);
    cyc = 0;
    @(negedge clk);
    while (!(busy && !rk_valid) && cyc < 50) begin
      @(negedge clk);
      cyc++;
    end
    chk("reach_expand", {127'b0, busy && !rk_valid}, 128'd1);
    #1 rst_n = 1'b0;
    #1 check_idle_outputs("async_rst");
    exp_q.delete();
    repeat (2) @(negedge clk);
    chk("rst_no_done", {127'b0, done}, 128'd0);
    rst_n = 1'b1;
    do_start(KEY_C3);
    wait_done(1'b1);
    chk("post_rst_idx14", got_rk[14], 128'h24fc79ccbf0979e9371ac23c6d68de36);

    // start with abort in IDLE: nothing happens.
    @(posedge clk);
    #1 start = 1'b1;
    abort = 1'b1;
    key_in = KEY_C3;
    @(posedge clk);
    #1 start = 1'b0;
    abort = 1'b0;
    @(negedge clk);
    chk("idle_abort_busy", {127'b0, busy}, 128'd0);
    chk("idle_abort_valid", {127'b0, rk_valid}, 128'd0);
    @(negedge clk);
    chk("idle_abort_busy2", {127'b0, busy}, 128'd0);

    // Random keys with random backpressure.
    rand_ready = 1'b1;
    for (int n = 0; n < 4; n++) begin
      rkey = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
      do_start(rkey);
      wait_done(1'b0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/key_sched_256_seq.md
KEY_SCHED_256_SEQ -- requirements
Module: key_sched_256_seq

Interface
REQ-001 The block SHALL have one clock and one reset: clock `clk`; reset `rst_n`, asynchronous, active-low.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst_n  input  1  asynchronous active-low reset.
REQ-004 start  input  1  begin a schedule; sampled only in IDLE.
REQ-005 abort  input  1  synchronous cancel of a schedule in progress.
REQ-006 key_in  input  256  cipher key, bits [255:224] = w0, down to [31:0] = w7; captured on accepted start.
REQ-007 rk_valid  output  1  round key presented.
REQ-008 rk_ready  input  1  consumer accepts; transfer when rk_valid && rk_ready.
REQ-009 rk_data  output  128  current round key, word order w(4i)..w(4i+3), MSB first.
REQ-010 rk_index  output  4  round number of rk_data, 0..14.
REQ-011 busy  output  1  high whenever state != IDLE.
REQ-012 done  output  1  one-cycle pulse after round key 14 is accepted.

Function
REQ-013 The block SHALL contain one combinational AES-256 expansion step (FIPS-197): first half uses RotWord+SubWord+Rcon on w7; second half uses SubWord only on the new w3. It SHALL be the only S-box resource; it is applied once per EXPAND cycle.
REQ-014 State registers: key_reg[255:0], rcon_reg[7:0], idx[3:0], FSM states IDLE, EMIT_A, EMIT_B, EXPAND.
REQ-015 IDLE + start + !abort: key_reg<=key_in, rcon_reg<=8'h01, idx<=0, next EMIT_A; start is ignored outside IDLE.
REQ-016 EMIT_A: rk_valid=1, rk_data=key_reg[255:128], rk_index=idx; on transfer: if idx==14 -> IDLE with done pulse, else idx<=idx+1, next EMIT_B.
REQ-017 EMIT_B: rk_valid=1, rk_data=key_reg[127:0], rk_index=idx; on transfer idx<=idx+1, next EXPAND.
REQ-018 EXPAND (exactly 1 cycle, rk_valid=0): key_reg<=expand(key_reg, {rcon_reg,24'h0}); rcon_reg<=xtime(rcon_reg), i.e. {rcon[6:0],1'b0} ^ (rcon[7] ? 8'h1b : 0); next EMIT_A.
REQ-019 Rcon sequence used SHALL be 01,02,04,08,10,20,40 across the 7 EXPAND cycles; the eighth value is never consumed.
REQ-020 Latency: rk_valid first high the cycle after start is sampled; every odd→even index gap is exactly one bubble cycle; no bubble between even→odd.
REQ-021 While rk_valid && !rk_ready, rk_data and rk_index SHALL hold stable; rk_valid SHALL not drop without a transfer except on abort or reset.
REQ-022 done SHALL assert for exactly one cycle, the cycle after the index-14 transfer, coincident with busy=0.
REQ-023 abort in any non-IDLE state: next state IDLE, rk_valid=0 next cycle, no done pulse; a concurrent transfer in that cycle still counts as delivered. abort in IDLE has no effect and suppresses a same-cycle start.
REQ-024 The block SHALL produce exactly 15 transfers per uninterrupted schedule; indices strictly 0..14 with no repeats or skips.

Reset
REQ-025 On rst_n low, asynchronously: state=IDLE, rk_valid=0, done=0, busy=0, rk_index=0, rk_data=0, key_reg=0, rcon_reg=8'h01, idx=0.
REQ-026 Reset asserted mid-schedule SHALL abandon it without done; after release the block SHALL accept a new start normally.

Verification
REQ-027 FIPS-197 C.3 key 000102..1f, rk_ready=1: idx0=00010203..0c0d0e0f, idx1=10111213..1c1d1e1f, idx2=a573c29fa176c498a97fce93a572c09c, idx14=24fc79ccbf0979e9371ac23c6d68de36; done 1 cycle after idx14; 21 cycles start→done.
REQ-028 Same key, rk_ready toggled pseudo-randomly: identical 15-key sequence; rk_data/rk_index stable during every stall.
REQ-029 start pulsed while busy at idx 5 -> ignored; sequence and final key unchanged.
REQ-030 abort in EMIT_B at idx 7 -> IDLE next cycle, no done; immediate new start with all-zero key yields idx2=62636363626363636263636362636363.
REQ-031 rst_n low during EXPAND -> all outputs at reset values asynchronously; after release, full C.3 run passes.
REQ-032 start and abort same cycle in IDLE -> stays IDLE, busy=0, rk_valid=0.
